// File: rtl/blake_round_if.sv
// Message-in and digest-out handshakes between a block source/digest sink and the
// Blake-512 round controller.
interface blake_round_if;
  logic        msg_valid;
  logic        msg_last;
  logic [10:0] msg_bits;
  logic        msg_ready;
  logic        hash_valid;
  logic        hash_ready;

  modport master (
    output msg_valid,
    output msg_last,
    output msg_bits,
    input  msg_ready,
    input  hash_valid,
    output hash_ready
  );

  modport slave (
    input  msg_valid,
    input  msg_last,
    input  msg_bits,
    output msg_ready,
    output hash_valid,
    input  hash_ready
  );
endinterface

// File: rtl/blake_round_ctrl.sv
// Blake-512 block sequencer: accepts 1024-bit blocks, runs one 64-step sweep of the
// 2G core, waits for the step counter's delayed ready, finalises, and emits the digest.
module blake_round_ctrl #(
  parameter int DRAIN_MAX = 80,
  parameter int T_W       = 128
) (
  input  logic           clk,
  input  logic           rstb,
  blake_round_if.slave   bus,
  output logic           init_en,
  output logic [T_W-1:0] t_out,
  output logic           round_ing,
  input  logic           count_done,
  input  logic           rdy_from_counter,
  output logic           final_en,
  output logic           busy,
  output logic           err
);

  localparam int DC_W = $clog2(DRAIN_MAX);
  localparam logic [DC_W-1:0] DRAIN_LAST = DC_W'(DRAIN_MAX - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DRAIN,
    S_FINAL,
    S_OUT
  } state_t;

  state_t          state_q, state_d;
  logic [T_W-1:0]  t_acc_q, t_acc_d;
  logic [T_W-1:0]  t_out_q, t_out_d;
  logic [DC_W-1:0] drain_cnt_q, drain_cnt_d;
  logic            last_q, last_d;
  logic            init_en_q, init_en_d;
  logic            round_ing_q, round_ing_d;
  logic            final_en_q, final_en_d;
  logic            hash_valid_q, hash_valid_d;
  logic            busy_q, busy_d;
  logic            err_q, err_d;
  logic [T_W-1:0]  blk_bits;

  // A block never carries more than 1024 message bits.
  function automatic logic [10:0] sat_bits(input logic [10:0] bits);
    return (bits > 11'd1024) ? 11'd1024 : bits;
  endfunction

  assign blk_bits = T_W'(sat_bits(bus.msg_bits));

  always_comb begin
    state_d      = state_q;
    t_acc_d      = t_acc_q;
    t_out_d      = t_out_q;
    drain_cnt_d  = drain_cnt_q;
    last_d       = last_q;
    init_en_d    = 1'b0;
    round_ing_d  = round_ing_q;
    final_en_d   = 1'b0;
    hash_valid_d = hash_valid_q;
    busy_d       = busy_q;
    err_d        = err_q;

    case (state_q)
      S_IDLE: begin
        if (bus.msg_valid) begin
          last_d    = bus.msg_last;
          t_acc_d   = t_acc_q + blk_bits;
          // A padding-only block is hashed with counter 0, but t still accumulates.
          t_out_d   = (bus.msg_bits == 11'd0) ? '0 : t_acc_d;
          init_en_d = 1'b1;
          busy_d    = 1'b1;
          state_d   = S_LOAD;
        end
      end
      S_LOAD: begin
        round_ing_d = 1'b1;
        state_d     = S_RUN;
      end
      S_RUN: begin
        if (count_done) begin
          round_ing_d = 1'b0;
          drain_cnt_d = '0;
          state_d     = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (rdy_from_counter) begin
          drain_cnt_d = '0;
          final_en_d  = 1'b1;
          state_d     = S_FINAL;
        end else if (drain_cnt_q == DRAIN_LAST) begin
          drain_cnt_d = '0;
          err_d       = 1'b1;
          final_en_d  = 1'b1;
          state_d     = S_FINAL;
        end else begin
          drain_cnt_d = drain_cnt_q + DC_W'(1);
        end
      end
      S_FINAL: begin
        if (last_q) begin
          hash_valid_d = 1'b1;
          state_d      = S_OUT;
        end else begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      S_OUT: begin
        if (bus.hash_ready) begin
          hash_valid_d = 1'b0;
          t_acc_d      = '0;
          busy_d       = 1'b0;
          state_d      = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q      <= S_IDLE;
      t_acc_q      <= '0;
      t_out_q      <= '0;
      drain_cnt_q  <= '0;
      last_q       <= 1'b0;
      init_en_q    <= 1'b0;
      round_ing_q  <= 1'b0;
      final_en_q   <= 1'b0;
      hash_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      t_acc_q      <= t_acc_d;
      t_out_q      <= t_out_d;
      drain_cnt_q  <= drain_cnt_d;
      last_q       <= last_d;
      init_en_q    <= init_en_d;
      round_ing_q  <= round_ing_d;
      final_en_q   <= final_en_d;
      hash_valid_q <= hash_valid_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
    end
  end

  // Gated by rstb so the source sees "not ready" for the whole reset window.
  assign bus.msg_ready  = rstb & (state_q == S_IDLE);
  assign bus.hash_valid = hash_valid_q;
  assign init_en        = init_en_q;
  assign t_out          = t_out_q;
  assign round_ing      = round_ing_q;
  assign final_en       = final_en_q;
  assign busy           = busy_q;
  assign err            = err_q;

endmodule

// File: tb/tb_blake_round_ctrl.sv
// Bench for blake_round_ctrl: stubbed step counter, directed vector table, reset corner
// cases and a randomized block stream checked against a transaction-level model.
module tb_blake_round_ctrl;

  logic         clk = 1'b0;
  logic         rstb = 1'b0;
  logic         init_en, round_ing, final_en, busy, err;
  logic [127:0] t_out;
  logic         count_done, rdy_from_counter;
  logic         spur_cd = 1'b0, spur_rdy = 1'b0, rdy_block = 1'b0;
  logic [5:0]   cidx;
  logic [63:0]  dline;
  logic         stub_cd;

  int n_checks = 0;
  int n_err    = 0;

  blake_round_if bus();

  blake_round_ctrl #(.DRAIN_MAX(80), .T_W(128)) dut (
    .clk              (clk),
    .rstb             (rstb),
    .bus              (bus),
    .init_en          (init_en),
    .t_out            (t_out),
    .round_ing        (round_ing),
    .count_done       (count_done),
    .rdy_from_counter (rdy_from_counter),
    .final_en         (final_en),
    .busy             (busy),
    .err              (err)
  );

  always #5 clk = ~clk;

  // Step-counter stub: 6-bit index advanced by round_ing, done flag delayed 64 cycles.
  assign stub_cd          = (cidx == 6'd63);
  assign count_done       = stub_cd | spur_cd;
  assign rdy_from_counter = (dline[63] & ~rdy_block) | spur_rdy;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      cidx  <= '0;
      dline <= '0;
    end else begin
      if (round_ing) cidx <= cidx + 6'd1;
      dline <= {dline[62:0], stub_cd};
    end
  end

  typedef struct {
    logic [10:0]  bits;
    bit           last;
    bit           stuck;
    int           hr_wait;
    bit           spur;
    logic [127:0] exp_t;
    bit           exp_err;
  } vec_t;

  typedef struct {
    int           init_at, init_n, run_first, run_last, run_n;
    int           fin_at, fin_n, hv_at, hv_n, idle_at, rdy_bad, busy_bad;
    bit           tmo, post_rdy, post_busy, err;
    logic [127:0] t;
  } res_t;

  vec_t tbl[10];

  function automatic void chk(string nm, logic [127:0] act, logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endfunction

  // Applies one block starting at a negedge and records what the outputs did,
  // counting cycles from the accept edge (k = 1 is the cycle after accept).
  task automatic run_block(input logic [10:0] bits, input bit last, input bit stuck,
                           input int hr_wait, input bit spur, output res_t r);
    int  k;
    int  guard;
    int  hv_n;
    bit  done;
    bit  idle_now;
    r = '{default: 0};
    r.init_at = -1; r.run_first = -1; r.fin_at = -1; r.hv_at = -1; r.idle_at = -1;
    rdy_block = stuck;
    bus.hash_ready = 1'b1;
    guard = 0;
    while (!bus.msg_ready && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    bus.msg_valid = 1'b1;
    bus.msg_bits  = bits;
    bus.msg_last  = last;
    @(negedge clk);
    bus.msg_valid = 1'b0;
    bus.msg_bits  = 11'($urandom);
    bus.msg_last  = 1'($urandom);
    k = 1; done = 1'b0; hv_n = 0;
    while (!done && k < 400) begin
      idle_now = 1'b0;
      if (k == 1) r.t = t_out;
      if (init_en) begin
        if (r.init_at < 0) r.init_at = k;
        r.init_n++;
      end
      if (round_ing) begin
        if (r.run_first < 0) r.run_first = k;
        r.run_last = k;
        r.run_n++;
      end
      if (final_en) begin
        if (r.fin_at < 0) r.fin_at = k;
        r.fin_n++;
      end
      if (bus.msg_ready) begin
        if (last) r.rdy_bad++;
        else begin
          r.idle_at = k;
          idle_now  = 1'b1;
          done      = 1'b1;
        end
      end
      if (idle_now ? busy : !busy) r.busy_bad++;
      spur_rdy = spur && (k == 10);
      spur_cd  = spur && (k == 100);
      if (bus.hash_valid) begin
        hv_n++;
        r.hv_n++;
        if (r.hv_at < 0) r.hv_at = k;
        bus.hash_ready = (hv_n > hr_wait);
        // Offer a new block while the digest is stalled; it must be refused.
        bus.msg_valid  = !bus.hash_ready;
        if (bus.hash_ready) done = 1'b1;
      end
      if (!done) begin
        @(negedge clk);
        k++;
      end
    end
    r.tmo = !done;
    bus.msg_valid  = 1'b0;
    bus.hash_ready = 1'b1;
    spur_rdy = 1'b0;
    spur_cd  = 1'b0;
    if (last && done) begin
      @(negedge clk);
      r.post_rdy  = bus.msg_ready;
      r.post_busy = busy;
    end
    r.err = err;
    rdy_block = 1'b0;
  endtask

  task automatic check_block(input string tag, input vec_t v, input res_t r);
    int fin;
    fin = v.stuck ? 146 : 130;
    chk({tag, "_timeout"},   32'(r.tmo), 0);
    chk({tag, "_t_out"},     r.t, v.exp_t);
    chk({tag, "_init_at"},   r.init_at, 1);
    chk({tag, "_init_n"},    r.init_n, 1);
    chk({tag, "_run_first"}, r.run_first, 2);
    chk({tag, "_run_last"},  r.run_last, 65);
    chk({tag, "_run_n"},     r.run_n, 64);
    chk({tag, "_fin_at"},    r.fin_at, fin);
    chk({tag, "_fin_n"},     r.fin_n, 1);
    chk({tag, "_rdy_bad"},   r.rdy_bad, 0);
    chk({tag, "_busy_bad"},  r.busy_bad, 0);
    chk({tag, "_err"},       32'(r.err), 32'(v.exp_err));
    if (v.last) begin
      chk({tag, "_hv_at"},     r.hv_at, fin + 1);
      chk({tag, "_hv_n"},      r.hv_n, v.hr_wait + 1);
      chk({tag, "_post_rdy"},  32'(r.post_rdy), 1);
      chk({tag, "_post_busy"}, 32'(r.post_busy), 0);
    end else begin
      chk({tag, "_hv_n"},    r.hv_n, 0);
      chk({tag, "_idle_at"}, r.idle_at, fin + 1);
    end
  endtask

  initial begin
    res_t         r;
    vec_t         v;
    logic [127:0] t_acc_m;
    logic [10:0]  sb;
    bit           err_m;
    int           sel;

    bus.msg_valid  = 1'b0;
    bus.msg_last   = 1'b0;
    bus.msg_bits   = '0;
    bus.hash_ready = 1'b1;

    //            bits      last  stuck hr  spur exp_t        exp_err
    tbl[0] = '{11'd1024, 1'b1, 1'b0, 0,  1'b0, 128'd1024, 1'b0};
    tbl[1] = '{11'd1024, 1'b0, 1'b0, 0,  1'b1, 128'd1024, 1'b0};
    tbl[2] = '{11'd200,  1'b1, 1'b0, 0,  1'b0, 128'd1224, 1'b0};
    tbl[3] = '{11'd1024, 1'b0, 1'b0, 0,  1'b0, 128'd1024, 1'b0};
    tbl[4] = '{11'd0,    1'b1, 1'b0, 10, 1'b0, 128'd0,    1'b0};
    tbl[5] = '{11'd1500, 1'b0, 1'b0, 0,  1'b0, 128'd1024, 1'b0};
    tbl[6] = '{11'd0,    1'b0, 1'b0, 0,  1'b1, 128'd0,    1'b0};
    tbl[7] = '{11'd100,  1'b1, 1'b0, 2,  1'b0, 128'd1124, 1'b0};
    tbl[8] = '{11'd512,  1'b1, 1'b1, 0,  1'b0, 128'd512,  1'b1};
    tbl[9] = '{11'd300,  1'b1, 1'b0, 1,  1'b0, 128'd300,  1'b1};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_init_en",    32'(init_en), 0);
    chk("rst_round_ing",  32'(round_ing), 0);
    chk("rst_final_en",   32'(final_en), 0);
    chk("rst_hash_valid", 32'(bus.hash_valid), 0);
    chk("rst_busy",       32'(busy), 0);
    chk("rst_err",        32'(err), 0);
    chk("rst_msg_ready",  32'(bus.msg_ready), 0);
    chk("rst_t_out",      t_out, 0);
    rstb = 1'b1;
    @(negedge clk);
    chk("post_rst_msg_ready", 32'(bus.msg_ready), 1);
    chk("post_rst_busy",      32'(busy), 0);

    for (int i = 0; i < 10; i++) begin
      run_block(tbl[i].bits, tbl[i].last, tbl[i].stuck, tbl[i].hr_wait, tbl[i].spur, r);
      check_block($sformatf("vec%0d", i), tbl[i], r);
    end

    // Reset during the sweep, after 30 steps
    bus.msg_valid = 1'b1;
    bus.msg_bits  = 11'd700;
    bus.msg_last  = 1'b1;
    @(negedge clk);
    bus.msg_valid = 1'b0;
    repeat (30) @(negedge clk);
    chk("midrst_running", 32'(round_ing), 1);
    rstb = 1'b0;
    #1;
    chk("midrst_round_ing", 32'(round_ing), 0);
    chk("midrst_busy",      32'(busy), 0);
    chk("midrst_msg_ready", 32'(bus.msg_ready), 0);
    chk("midrst_err",       32'(err), 0);
    chk("midrst_t_out",     t_out, 0);
    @(negedge clk);
    rstb = 1'b1;
    @(negedge clk);
    chk("midrst_rel_ready", 32'(bus.msg_ready), 1);
    chk("midrst_rel_busy",  32'(busy), 0);
    v = '{11'd1024, 1'b1, 1'b0, 0, 1'b0, 128'd1024, 1'b0};
    run_block(v.bits, v.last, v.stuck, v.hr_wait, v.spur, r);
    check_block("midrst_blk", v, r);

    // Random block stream against the transaction model
    t_acc_m = '0;
    err_m   = 1'b0;
    for (int i = 0; i < 20; i++) begin
      sel = $urandom_range(0, 3);
      case (sel)
        0:       v.bits = 11'd0;
        1:       v.bits = 11'd1024;
        2:       v.bits = 11'($urandom_range(1025, 2047));
        default: v.bits = 11'($urandom_range(1, 1023));
      endcase
      v.last    = ($urandom_range(0, 2) == 0);
      v.stuck   = ($urandom_range(0, 7) == 0);
      v.hr_wait = $urandom_range(0, 3);
      v.spur    = 1'($urandom_range(0, 1));
      sb        = (v.bits > 11'd1024) ? 11'd1024 : v.bits;
      t_acc_m   = t_acc_m + 128'(sb);
      v.exp_t   = (v.bits == 11'd0) ? 128'd0 : t_acc_m;
      err_m     = err_m | v.stuck;
      v.exp_err = err_m;
      if (v.last) t_acc_m = '0;
      run_block(v.bits, v.last, v.stuck, v.hr_wait, v.spur, r);
      check_block($sformatf("rnd%0d", i), v, r);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/blake_round_ctrl.md
Name: blake_round_ctrl

Overview:
- Control FSM directly upstream of the 2G-core step counter.
- Accepts one 1024-bit message block per valid/ready handshake and initialises the core state.
- Drives round_ing for exactly one 64-step sweep (16 rounds × 8 G / 2 G units), then waits for the counter's delayed ready pulse and finalises.
- Maintains the Blake-512 bit counter t, and presents the digest with a valid/ready handshake after the last block.

Parameters:
- DRAIN_MAX, 80, max cycles in DRAIN waiting for rdy_from_counter before flagging err (must be ≥ 65).
- T_W, 128, width of the Blake bit counter t.

Ports:
- clk  in  1  clock.
- rstb  in  1  reset, asynchronous, active-low.
- msg_valid  in  1  message block present.
- msg_last  in  1  block is the final block of the message; qualified by msg_valid.
- msg_bits  in  11  message bits in this block, 0..1024; qualified by msg_valid.
- msg_ready  out  1  controller can accept a block.
- init_en  out  1  one-cycle pulse: load chaining value, salt, t and block into the core.
- t_out  out  T_W  counter value used for the current block.
- round_ing  out  1  step-enable to blake_counter.
- count_done  in  1  from blake_counter (counter_idx == 63).
- rdy_from_counter  in  1  from blake_counter, count_done delayed by 64 cycles.
- final_en  out  1  one-cycle pulse: h' = h ^ s ^ v_lo ^ v_hi.
- hash_valid  out  1  digest valid (last block only).
- hash_ready  in  1  digest consumer ready.
- busy  out  1  high in any state except IDLE.
- err  out  1  sticky drain timeout flag.

Behaviour:
- Reset values: all outputs 0; state IDLE; t_acc = 0; drain_cnt = 0; last_q = 0.
- msg_ready is 1 only in IDLE, combinational from state.
- States and transitions:
  - IDLE: on msg_valid & msg_ready, latch last_q = msg_last, t_acc += msg_bits (mod 2^T_W); go to LOAD.
  - LOAD (1 cycle): init_en = 1; go to RUN.
  - RUN: round_ing = 1 on every cycle in RUN. In the cycle where count_done = 1 (the 64th RUN cycle), round_ing is still 1 so the counter wraps to 0. Next state is DRAIN, with round_ing = 0 from then on.
  - DRAIN: drain_cnt increments each cycle.
    - rdy_from_counter = 1 → FINAL, drain_cnt cleared.
    - drain_cnt reaches DRAIN_MAX first → set err, go to FINAL anyway.
    - Nominal rdy arrives 64 cycles after the count_done cycle, i.e. in DRAIN cycle 63 (first DRAIN cycle = cycle 0).
  - FINAL (1 cycle): final_en = 1.
    - last_q = 1 → OUT.
    - last_q = 0 → IDLE, with t_acc retained.
  - OUT: hash_valid = 1, held until hash_ready. On hash_valid & hash_ready: go to IDLE and clear t_acc to 0.
- t_out:
  - Registered and valid from the LOAD cycle until the next accept.
  - Value is (msg_bits == 0) ? 0 : updated t_acc. This is the Blake rule that a padding-only block uses counter 0; t_acc itself still adds 0.
- Spurious inputs:
  - rdy_from_counter outside DRAIN is ignored.
  - count_done outside RUN is ignored.
  - msg_bits > 1024 is saturated to 1024.
- err: sticky; cleared only by reset.
- Reset mid-operation: asynchronous return to IDLE, all outputs low immediately. blake_counter shares rstb, so no partial sweep survives.
- Latency, single block with rdy nominal: accept → init_en at +1 → round_ing for cycles +2..+65 → DRAIN → final_en at +130 → hash_valid at +131.

Test Plan:
- Single last block, msg_bits = 1024, hash_ready tied 1 → init_en at +1; round_ing high for exactly 64 cycles; final_en at +130; hash_valid for 1 cycle at +131; t_out = 1024.
- Two blocks (1024 then last with 200 bits) → second t_out = 1224; no hash_valid after block 1; after handshake, t_acc = 0 and msg_ready = 1.
- Last block with msg_bits = 0 after a 1024-bit block → t_out = 0; t_acc stays 1024 until the hash handshake.
- Hold rdy_from_counter low (blake_counter stubbed) → err sets after DRAIN_MAX = 80 DRAIN cycles; FINAL still pulses; err persists across the following blocks.
- hash_ready low for 10 cycles in OUT → hash_valid stays 1 and msg_ready stays 0 until the handshake; msg_valid pulses meanwhile are not accepted.
- Deassert rstb during RUN at step 30 → round_ing, busy and msg_ready drop at once; after release, state is IDLE, msg_ready = 1, and a new block runs a full 64-step sweep.
